// File: rtl/bcd_pkg.sv
// bcd_pkg: shared defaults, FSM encoding and sizing helpers for the sequential BCD converter.
package bcd_pkg;
    localparam int BIN_W_DEF  = 16;
    localparam int DIGITS_DEF = 5;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

    function automatic bit digits_fit(input int bin_w, input int digits);
        longint unsigned p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p > (64'd1 << bin_w) - 1;
    endfunction
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble digit correction, adds 3 to any digit of 5 or more.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, BIN_W+2 cycles per result.
// Optional BIN2BCD_AUTO_EN: a change of bin while idle starts a conversion without start.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = BIN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk_10kHz,
    input  logic                  clrn,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = cnt_w(BIN_W);

    if (!digits_fit(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small for BIN_W");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   acc_q, acc_d;
    logic [BIN_W-1:0]      sr_q, sr_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   adj;
    logic                  trig;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (.d_i(acc_q[4*g +: 4]), .q_o(adj[4*g +: 4]));
    end

`ifdef BIN2BCD_AUTO_EN
    logic [BIN_W-1:0] last_q, last_d;
    assign trig = start || (bin != last_q);
    always_ff @(posedge clk_10kHz or negedge clrn) begin
        if (!clrn) last_q <= '0;
        else       last_q <= last_d;
    end
    always_comb last_d = (state_q == LOAD) ? bin : last_q;
`else
    assign trig = start;
`endif

    always_ff @(posedge clk_10kHz or negedge clrn) begin
        if (!clrn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sr_q    <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sr_q    <= sr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sr_d    = sr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (trig) state_d = LOAD;
            LOAD: begin
                acc_d   = '0;
                sr_d    = bin;
                cnt_d   = CW'(BIN_W);
                state_d = SHIFT;
            end
            SHIFT: begin
                // digits are corrected before the whole register moves left
                {acc_d, sr_d} = {adj, sr_q} << 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == LOAD) || (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed bench with a timeline model of the converter checked every cycle.
`timescale 1us/1ns
module tb_bin2bcd_seq;
    localparam int BW = 16;
    localparam int DG = 5;

    logic            clk_10kHz = 1'b0;
    logic            clrn = 1'b0;
    logic            start = 1'b0;
    logic [BW-1:0]   bin = '0;
    logic            busy, done;
    logic [4*DG-1:0] bcd;

    int n_cmp = 0;
    int n_err = 0;

    int              phase = -1;
    logic [BW-1:0]   cap = '0;
    logic [BW-1:0]   last = '0;
    logic [4*DG-1:0] exp_bcd = '0;
    logic            auto_trig;

    logic [BW-1:0]   sw_in  [8] = '{16'd4, 16'd9, 16'd200, 16'd700, 16'd2500, 16'd6000, 16'd2540, 16'd2794};
    logic [4*DG-1:0] sw_out [8] = '{20'h00004, 20'h00009, 20'h00200, 20'h00700, 20'h02500, 20'h06000, 20'h02540, 20'h02794};

    bin2bcd_seq #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk_10kHz(clk_10kHz), .clrn(clrn), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd)
    );

    always #50 clk_10kHz = ~clk_10kHz;

    function automatic logic [4*DG-1:0] to_bcd(input int v);
        logic [4*DG-1:0] r = '0;
        for (int i = 0; i < DG; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

`ifdef BIN2BCD_AUTO_EN
    assign auto_trig = (bin != last);
`else
    assign auto_trig = 1'b0;
`endif

    // phase counts edges since a conversion was accepted; -1 means idle
    always @(posedge clk_10kHz or negedge clrn) begin
        if (!clrn) begin
            phase   = -1;
            exp_bcd = '0;
            last    = '0;
        end else if (phase == -1 || phase == BW + 2) begin
            if (start || auto_trig) begin
                phase = 0;
                cap   = bin;
                last  = bin;
            end else phase = -1;
        end else begin
            phase = phase + 1;
            if (phase == BW + 2) exp_bcd = to_bcd(int'(cap));
        end
    end

    always @(negedge clk_10kHz) begin
        n_cmp++;
        if (busy !== (phase >= 0 && phase <= BW) || done !== (phase == BW + 2) || bcd !== exp_bcd) begin
            n_err++;
            $display("FAIL cycle t=%0t: busy=%b done=%b bcd=%h, want busy=%b done=%b bcd=%h", $time,
                     busy, done, bcd, (phase >= 0 && phase <= BW), (phase == BW + 2), exp_bcd);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic run(input logic [BW-1:0] v, input logic [4*DG-1:0] want);
        int k;
        int nb = 0;
        check("model_pin", 32'(to_bcd(int'(v))), 32'(want));
        bin   = v;
        start = 1'b1;
        for (k = 0; k < 40; k++) begin
            @(posedge clk_10kHz); #1;
            start = 1'b0;
            if (done) break;
            if (busy) nb++;
        end
        check("latency", 32'(k), 32'd18);
        check("busy_cycles", 32'(nb), 32'd17);
        check("bcd", 32'(bcd), 32'(want));
        @(posedge clk_10kHz); #1;
        check("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        #5;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd), 32'd0);
        #5 clrn = 1'b1;
        repeat (50) @(posedge clk_10kHz);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_bcd", 32'(bcd), 32'd0);

        run(16'd1, 20'h00001);
        for (int i = 0; i < 8; i++) run(sw_in[i], sw_out[i]);
        run(16'hFFFF, 20'h65535);
        run(16'd0, 20'h00000);

        begin
            int ndone = 0;
            bin   = 16'd100;
            start = 1'b1;
            for (int c = 0; c < 40; c++) begin
                @(posedge clk_10kHz); #1;
                start = (c == 5);
                if (c == 5)  bin = 16'd999;
                if (c == 10) bin = 16'd4321;
                if (c == 15) bin = 16'd100;
                if (done) ndone++;
            end
            check("busy_start_dones", 32'(ndone), 32'd1);
            check("busy_start_bcd", 32'(bcd), 32'h00100);
        end

        bin   = 16'd12345;
        start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk_10kHz); #1;
            start = 1'b0;
        end
        clrn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        bin = '0;
        repeat (3) @(posedge clk_10kHz);
        #1 clrn = 1'b1;
        repeat (30) @(posedge clk_10kHz);
        #1;
        check("postrst_bcd", 32'(bcd), 32'd0);
        run(16'd12345, 20'h12345);

`ifdef BIN2BCD_AUTO_EN
        run(16'd30, 20'h00030);
        begin
            int k;
            bin = 16'd600;
            for (k = 0; k < 25; k++) begin
                @(posedge clk_10kHz); #1;
                if (done) break;
            end
            check("auto_latency_ok", 32'(k <= 19), 32'd1);
            check("auto_bcd", 32'(bcd), 32'h00600);
        end
`endif

        @(posedge clk_10kHz); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
